vdc_cpu_if: RTL

- CPU-side register front end of the VDC; sits directly upstream of the VDC RAM access engine.
- Decodes the two-byte CPU window: address/status port (rs=0) and data port (rs=1).
- Holds the 37-entry register file R0..R36 and converts data-port writes into one-cycle `update`/`regSel`/`db_out` strobes for the RAM engine.
- Defers RAM-engine writes while that engine reports busy, and returns status and RAM-engine registers on reads.

---
 rtl/vdc_cpu_if_if.sv | 12 +
 rtl/vdc_cpu_if.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/vdc_cpu_if_if.sv
// CPU bus window of the VDC: chip select, direction, port select and data.
// The CPU (or bench) is the master; the VDC register front end is the slave.
interface vdc_cpu_if_if;
  logic       cs;
  logic       we;
  logic       rs;
  logic [7:0] cpu_di;
  logic [7:0] cpu_do;

  modport master (output cs, output we, output rs, output cpu_di, input cpu_do);
  modport slave  (input cs, input we, input rs, input cpu_di, output cpu_do);
endinterface

// File: rtl/vdc_cpu_if.sv
// VDC CPU-side register front end: address/data port decode, R0..R36 register
// file, and update strobes to the RAM access engine with busy-deferred writes.
module vdc_cpu_if #(
  parameter logic [2:0] VERSION = 3'd2
) (
  input  logic              clk,
  input  logic              reset,
  vdc_cpu_if_if.slave       bus,
  output logic              update,
  output logic [7:0]        regSel,
  output logic [7:0]        db_out,
  output logic              reg_copy,
  output logic              ramsize,
  input  logic [15:0]       reg_ua,
  input  logic [7:0]        reg_wc,
  input  logic [7:0]        reg_da,
  input  logic [15:0]       reg_ba,
  input  logic              busy,
  input  logic              vblank,
  input  logic              lp_strobe,
  input  logic [5:0]        dispSel,
  output logic [7:0]        dispVal
);

  localparam int         NREG     = 37;
  localparam logic [7:0] LAST_REG = 8'd36;

  typedef enum logic [1:0] {IDLE, WAIT, PULSE} state_t;

  state_t      state_q, state_d;
  logic        cs_d, lp_d, lp_flag;
  logic        pending, pending_d;
  logic [7:0]  addr_q;
  logic [7:0]  pend_sel, pend_sel_d, pend_data, pend_data_d;
  logic [7:0]  regsel_d, db_out_d, rd_val;
  logic [7:0]  regfile [NREG];
  logic        access, wr_addr, rd_stat, wr_data, rd_data;

  // Registers whose writes the RAM engine cannot accept while it is busy.
  function automatic logic is_ram(input logic [7:0] idx);
    return (idx == 8'd18) || (idx == 8'd19) || (idx == 8'd30) || (idx == 8'd31);
  endfunction

  assign access  = bus.cs & ~cs_d;
  assign wr_addr = access & ~bus.rs &  bus.we;
  assign rd_stat = access & ~bus.rs & ~bus.we;
  assign wr_data = access &  bus.rs &  bus.we;
  assign rd_data = access &  bus.rs & ~bus.we;

  assign update   = (state_q == PULSE);
  assign reg_copy = regfile[24][7];
  assign ramsize  = regfile[28][4];
  assign dispVal  = ({2'b00, dispSel} <= LAST_REG) ? regfile[dispSel] : 8'hFF;

  always_comb begin
    rd_val = 8'hFF;
    case (addr_q)
      8'd18:   rd_val = reg_ua[15:8];
      8'd19:   rd_val = reg_ua[7:0];
      8'd30:   rd_val = reg_wc;
      8'd31:   rd_val = reg_da;
      8'd32:   rd_val = reg_ba[15:8];
      8'd33:   rd_val = reg_ba[7:0];
      default: if (addr_q <= LAST_REG) rd_val = regfile[addr_q[5:0]];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending;
    pend_sel_d  = pend_sel;
    pend_data_d = pend_data;
    regsel_d    = regSel;
    db_out_d    = db_out;
    if (wr_addr) regsel_d = {2'b00, bus.cpu_di[5:0]};
    case (state_q)
      IDLE: begin
        if (wr_data) begin
          if (is_ram(addr_q) && busy) begin
            pend_sel_d  = addr_q;
            pend_data_d = bus.cpu_di;
            pending_d   = 1'b1;
            state_d     = WAIT;
          end else begin
            regsel_d = addr_q;
            db_out_d = bus.cpu_di;
            state_d  = PULSE;
          end
        end
      end
      WAIT: begin
        // A further data write replaces the pending one; the launch waits a cycle.
        if (wr_data) begin
          pend_sel_d  = addr_q;
          pend_data_d = bus.cpu_di;
        end else if (!(busy && is_ram(pend_sel))) begin
          regsel_d = pend_sel;
          db_out_d = pend_data;
          state_d  = PULSE;
        end
      end
      PULSE: begin
        pending_d = 1'b0;
        state_d   = IDLE;
        if (wr_data) begin
          pend_sel_d  = addr_q;
          pend_data_d = bus.cpu_di;
          pending_d   = 1'b1;
          state_d     = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cs_d       <= 1'b0;
      lp_d       <= 1'b0;
      lp_flag    <= 1'b0;
      pending    <= 1'b0;
      addr_q     <= '0;
      pend_sel   <= '0;
      pend_data  <= '0;
      regSel     <= '0;
      db_out     <= '0;
      bus.cpu_do <= '0;
      for (int i = 0; i < NREG; i++) regfile[i] <= '0;
    end else begin
      state_q   <= state_d;
      cs_d      <= bus.cs;
      lp_d      <= lp_strobe;
      pending   <= pending_d;
      pend_sel  <= pend_sel_d;
      pend_data <= pend_data_d;
      regSel    <= regsel_d;
      db_out    <= db_out_d;
      if (wr_addr) addr_q <= {2'b00, bus.cpu_di[5:0]};
      if (wr_data && (addr_q <= LAST_REG)) regfile[addr_q[5:0]] <= bus.cpu_di;
      if (rd_stat) bus.cpu_do <= {~(busy | pending), lp_flag, vblank, 2'b00, VERSION};
      if (rd_data) bus.cpu_do <= rd_val;
      // A new light-pen edge outranks the clear-on-read of R16/R17.
      if (lp_strobe && !lp_d)
        lp_flag <= 1'b1;
      else if (rd_data && ((addr_q == 8'd16) || (addr_q == 8'd17)))
        lp_flag <= 1'b0;
    end
  end

endmodule
